// File: rtl/jellyvl_stream_to_handshake.sv
// Source-side front end for jellyvl_cdc_handshake: a one-entry stream buffer feeding the
// four-phase src_in/src_send/src_rcv protocol, with data setup, optional idle gap and a counter.
module jellyvl_stream_to_handshake #(
  parameter int WIDTH      = 4,
  parameter int GAP_CYCLES = 0,
  parameter int COUNT_BITS = 16
) (
  input  logic                  reset,
  input  logic                  clk,
  input  logic [WIDTH-1:0]      s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [WIDTH-1:0]      hsk_in,
  output logic                  hsk_send,
  input  logic                  hsk_rcv,
  output logic                  busy,
  output logic [COUNT_BITS-1:0] count
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SETUP   = 3'd1;
  localparam logic [2:0] SEND    = 3'd2;
  localparam logic [2:0] RELEASE = 3'd3;
  localparam logic [2:0] GAP     = 3'd4;

  localparam logic [7:0] GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  logic [2:0]       state;
  logic [2:0]       state_next;
  logic [WIDTH-1:0] buf_data;
  logic             buf_valid;
  logic [7:0]       gap_cnt;
  logic             accept;
  logic             drain;

  assign accept = s_valid && s_ready;
  // A stale ack left over from a reset must clear before a new word is presented.
  assign drain  = (state == IDLE) && buf_valid && !hsk_rcv;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (drain) state_next = SETUP;
      SETUP:   state_next = SEND;
      SEND:    if (hsk_rcv) state_next = RELEASE;
      RELEASE: if (!hsk_rcv) state_next = (GAP_CYCLES == 0) ? IDLE : GAP;
      GAP:     if (gap_cnt == 8'd0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      s_ready   <= 1'b0;
      buf_data  <= '0;
      buf_valid <= 1'b0;
      hsk_in    <= '0;
      hsk_send  <= 1'b0;
      gap_cnt   <= 8'd0;
      count     <= '0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
      // Ready stays low through the drain cycle, so an accept never coincides with a drain.
      s_ready <= !(accept || buf_valid);

      if (accept) begin
        buf_data  <= s_data;
        buf_valid <= 1'b1;
      end else if (drain) begin
        buf_valid <= 1'b0;
      end

      if (drain) hsk_in <= buf_data;

      if (state == SETUP) hsk_send <= 1'b1;

      if (state == SEND && hsk_rcv) begin
        hsk_send <= 1'b0;
        count    <= count + COUNT_BITS'(1);
      end

      if (state == RELEASE && !hsk_rcv) begin
        gap_cnt <= GAP_LOAD;
      end else if (state == GAP && gap_cnt != 8'd0) begin
        gap_cnt <= gap_cnt - 8'd1;
      end
    end
  end

endmodule
